// File: rtl/distribute_bytes.sv
// distribute_bytes: wide-to-narrow byte serializer.
// Accepts one C_IN_BYTES word and emits it C_OUT_BYTES at a time,
// least-significant bytes first. A final partial word is sized by a
// valid-byte count, and the last narrow word of a transfer is flagged.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   INDATA_EN/INDATA    wide input word and its valid strobe
//   INDATA_LAST         input word ends the transfer
//   INDATA_VALID_BYTES  valid bytes in the final word (0 = all)
//   INDATA_RD_EN        word accepted this cycle when INDATA_EN is high
//   OUTDATA_EN/OUTDATA  narrow output word and its valid strobe
//   OUTDATA_LAST        current narrow word is the last of the transfer
//   OUTDATA_RD_EN       narrow word consumed this cycle
//   DONE                one-cycle pulse after the last word is consumed
//
// Build option: define DISTRIBUTE_BYTES_ZERO_PAD_EN to force bytes past the
// valid-byte count to zero on the final narrow word of a transfer.
module distribute_bytes #(
    parameter int unsigned C_IN_BYTES  = 4,
    parameter int unsigned C_OUT_BYTES = 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              INDATA_EN,
    input  logic [8*C_IN_BYTES-1:0]           INDATA,
    input  logic                              INDATA_LAST,
    input  logic [$clog2(C_IN_BYTES+1)-1:0]   INDATA_VALID_BYTES,
    output logic                              INDATA_RD_EN,
    output logic                              OUTDATA_EN,
    output logic [8*C_OUT_BYTES-1:0]          OUTDATA,
    output logic                              OUTDATA_LAST,
    input  logic                              OUTDATA_RD_EN,
    output logic                              DONE
);

    localparam int unsigned C_IN_WIDTH  = 8 * C_IN_BYTES;
    localparam int unsigned C_OUT_WIDTH = 8 * C_OUT_BYTES;
    localparam int unsigned C_RATIO     = C_IN_BYTES / C_OUT_BYTES;
    localparam int unsigned C_REM_WIDTH = $clog2(C_RATIO + 1);
    localparam int unsigned C_VB_WIDTH  = $clog2(C_IN_BYTES + 1);

    logic [C_IN_WIDTH-1:0]  data_q, data_d;
    logic [C_REM_WIDTH-1:0] rem_q, rem_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;

    logic [C_VB_WIDTH-1:0]  vb_eff;
    logic [C_REM_WIDTH-1:0] rem_last;
    logic                   last_word;
    logic                   load;
    logic                   shift;

    // Effective valid-byte count: 0 and out-of-range values mean a full word
    always_comb begin
        if ((INDATA_VALID_BYTES == '0) ||
            (INDATA_VALID_BYTES > C_VB_WIDTH'(C_IN_BYTES))) begin
            vb_eff = C_VB_WIDTH'(C_IN_BYTES);
        end else begin
            vb_eff = INDATA_VALID_BYTES;
        end
    end

    // Narrow words needed for a final word: ceil(vb / C_OUT_BYTES)
    assign rem_last = C_REM_WIDTH'((32'(vb_eff) + C_OUT_BYTES - 32'd1) / C_OUT_BYTES);

    assign last_word    = (rem_q == C_REM_WIDTH'(1));
    assign OUTDATA_EN   = (rem_q != '0);
    assign OUTDATA_LAST = last_q & last_word;
    // Refill is allowed in the same cycle the final narrow word drains
    assign INDATA_RD_EN = (rem_q == '0) | (last_word & OUTDATA_RD_EN);
    assign DONE         = done_q;

    assign load  = INDATA_EN & INDATA_RD_EN;
    assign shift = OUTDATA_EN & OUTDATA_RD_EN;

`ifdef DISTRIBUTE_BYTES_ZERO_PAD_EN
    logic [C_VB_WIDTH-1:0] resid_q, resid_d;

    // Residual byte count of the final narrow word; 0 means every lane valid
    always_comb begin
        OUTDATA = data_q[C_OUT_WIDTH-1:0];
        if (OUTDATA_LAST && (resid_q != '0)) begin
            for (int b = 0; b < int'(C_OUT_BYTES); b++) begin
                if (C_VB_WIDTH'(b) >= resid_q) begin
                    OUTDATA[8*b +: 8] = 8'h00;
                end
            end
        end
    end

    always_comb begin
        resid_d = resid_q;
        if (load) begin
            resid_d = INDATA_LAST ? C_VB_WIDTH'(32'(vb_eff) % C_OUT_BYTES) : '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            resid_q <= '0;
        end else begin
            resid_q <= resid_d;
        end
    end
`else
    assign OUTDATA = data_q[C_OUT_WIDTH-1:0];
`endif

    // Next state: load has priority over shift so back-to-back words never bubble
    always_comb begin
        data_d = data_q;
        rem_d  = rem_q;
        last_d = last_q;
        done_d = OUTDATA_LAST & OUTDATA_RD_EN;
        if (load) begin
            data_d = INDATA;
            last_d = INDATA_LAST;
            rem_d  = INDATA_LAST ? rem_last : C_REM_WIDTH'(C_RATIO);
        end else if (shift) begin
            data_d = data_q >> C_OUT_WIDTH;
            rem_d  = rem_q - C_REM_WIDTH'(1);
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q <= '0;
            rem_q  <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            rem_q  <= rem_d;
            last_q <= last_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_distribute_bytes.sv
// Self-checking bench for distribute_bytes: directed vector table, hand
// sequences for reset and 4->2 partial words, then randomized traffic
// checked against a byte-queue reference model.
module tb_distribute_bytes;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    // 4 -> 1 instance
    logic        en, last, rd;
    logic [31:0] data;
    logic [2:0]  vb;
    logic        inrd, oen, olast, done;
    logic [7:0]  odata;

    // 4 -> 2 instance
    logic        en2, last2, rd2;
    logic [31:0] data2;
    logic [2:0]  vb2;
    logic        inrd2, oen2, olast2, done2;
    logic [15:0] odata2;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    distribute_bytes #(.C_IN_BYTES(4), .C_OUT_BYTES(1)) u_dut (
        .CLK(CLK), .RST(RST),
        .INDATA_EN(en), .INDATA(data), .INDATA_LAST(last),
        .INDATA_VALID_BYTES(vb), .INDATA_RD_EN(inrd),
        .OUTDATA_EN(oen), .OUTDATA(odata), .OUTDATA_LAST(olast),
        .OUTDATA_RD_EN(rd), .DONE(done)
    );

    distribute_bytes #(.C_IN_BYTES(4), .C_OUT_BYTES(2)) u_dut2 (
        .CLK(CLK), .RST(RST),
        .INDATA_EN(en2), .INDATA(data2), .INDATA_LAST(last2),
        .INDATA_VALID_BYTES(vb2), .INDATA_RD_EN(inrd2),
        .OUTDATA_EN(oen2), .OUTDATA(odata2), .OUTDATA_LAST(olast2),
        .OUTDATA_RD_EN(rd2), .DONE(done2)
    );

    typedef struct {
        logic        en;
        logic [31:0] data;
        logic        last;
        logic [2:0]  vb;
        logic        rd;
        logic        eoen;
        logic [7:0]  eout;
        logic        elast;
        logic        einrd;
        logic        edone;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } byte_t;

    vec_t  tbl[$];
    byte_t q[$];

    function automatic vec_t v(input logic en_i, input logic [31:0] d_i, input logic l_i,
                               input logic [2:0] vb_i, input logic rd_i, input logic oen_i,
                               input logic [7:0] o_i, input logic ol_i, input logic ir_i,
                               input logic dn_i);
        vec_t r;
        r.en = en_i; r.data = d_i; r.last = l_i; r.vb = vb_i; r.rd = rd_i;
        r.eoen = oen_i; r.eout = o_i; r.elast = ol_i; r.einrd = ir_i; r.edone = dn_i;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic        p_valid;
        logic [31:0] p_data;
        logic        p_last;
        logic [2:0]  p_vb;
        logic        done_pend;
        logic        e_inrd;
        int          nb;

        en = 0; data = '0; last = 0; vb = '0; rd = 0;
        en2 = 0; data2 = '0; last2 = 0; vb2 = '0; rd2 = 0;

        // Reset state
        #3;
        chk("rst_outen", 32'(oen), 0);
        chk("rst_outdata", 32'(odata), 0);
        chk("rst_outlast", 32'(olast), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_inrd", 32'(inrd), 1);
        tick();
        tick();
        RST = 0;

        // Full word, back-to-back words, partial last word, backpressure
        tbl.push_back(v(1, 32'h44332211, 0, 0, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h11, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h22, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h33, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h44, 0, 1, 0));
        tbl.push_back(v(1, 32'h44332211, 0, 0, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h11, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h22, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h33, 0, 0, 0));
        tbl.push_back(v(1, 32'h88776655, 1, 0, 1, 1, 8'h44, 0, 1, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h55, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h66, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h77, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h88, 1, 1, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 0, 8'h00, 0, 1, 1));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(1, 32'hDDCCBBAA, 1, 3, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'hAA, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'hBB, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'hCC, 1, 1, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 0, 8'h00, 0, 1, 1));
        tbl.push_back(v(1, 32'h44332211, 0, 0, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h11, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 8'h22, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 8'h22, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h22, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h33, 0, 0, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 8'h44, 0, 1, 0));
        tbl.push_back(v(0, 32'h0, 0, 0, 1, 0, 8'h00, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            tick();
            en = tbl[i].en; data = tbl[i].data; last = tbl[i].last;
            vb = tbl[i].vb; rd = tbl[i].rd;
            #3;
            chk($sformatf("vec%0d_outen", i), 32'(oen), 32'(tbl[i].eoen));
            if (tbl[i].eoen) begin
                chk($sformatf("vec%0d_outdata", i), 32'(odata), 32'(tbl[i].eout));
                chk($sformatf("vec%0d_outlast", i), 32'(olast), 32'(tbl[i].elast));
            end
            chk($sformatf("vec%0d_inrd", i), 32'(inrd), 32'(tbl[i].einrd));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].edone));
        end

        // Asynchronous reset in the middle of a transfer
        tick(); en = 1; data = 32'h44332211; last = 0; vb = 0; rd = 1;
        tick(); en = 0;
        tick();
        tick(); rd = 0;
        #1;
        chk("midrst_pre_outen", 32'(oen), 1);
        chk("midrst_pre_outdata", 32'(odata), 32'h33);
        RST = 1;
        #1;
        chk("midrst_outen", 32'(oen), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_inrd", 32'(inrd), 1);
        tick(); RST = 0;
        tick(); en = 1; data = 32'hA1B2C3D4; last = 0; rd = 1;
        #3;
        chk("postrst_done", 32'(done), 0);
        begin
            logic [31:0] w;
            w = 32'hA1B2C3D4;
            for (int i = 0; i < 4; i++) begin
                tick(); en = 0;
                #3;
                chk($sformatf("postrst_byte%0d", i), 32'(odata), 32'(w[8*i +: 8]));
                chk($sformatf("postrst_last%0d", i), 32'(olast), 0);
            end
        end
        tick();
        #3;
        chk("postrst_empty", 32'(oen), 0);
        chk("postrst_nodone", 32'(done), 0);

        // 4 -> 2 with a 3-byte final word
        tick(); en2 = 1; data2 = 32'h44332211; last2 = 1; vb2 = 3; rd2 = 1;
        #3;
        chk("w2_inrd0", 32'(inrd2), 1);
        tick(); en2 = 0;
        #3;
        chk("w2_outen1", 32'(oen2), 1);
        chk("w2_word1", 32'(odata2), 32'h2211);
        chk("w2_last1", 32'(olast2), 0);
        chk("w2_inrd1", 32'(inrd2), 0);
        tick();
        #3;
`ifdef DISTRIBUTE_BYTES_ZERO_PAD_EN
        chk("w2_word2", 32'(odata2), 32'h0033);
`else
        chk("w2_word2", 32'(odata2), 32'h4433);
`endif
        chk("w2_last2", 32'(olast2), 1);
        chk("w2_inrd2", 32'(inrd2), 1);
        tick();
        #3;
        chk("w2_outen3", 32'(oen2), 0);
        chk("w2_done3", 32'(done2), 1);
        tick();
        #3;
        chk("w2_done4", 32'(done2), 0);

        // Randomized traffic against a byte-queue model
        p_valid = 0; p_data = '0; p_last = 0; p_vb = '0; done_pend = 0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!p_valid && ($urandom_range(0, 3) != 0)) begin
                p_valid = 1;
                p_data  = $urandom;
                p_last  = ($urandom_range(0, 2) == 0);
                p_vb    = 3'($urandom_range(0, 7));
            end
            en   = p_valid;
            data = p_valid ? p_data : $urandom;
            last = p_valid ? p_last : 1'($urandom_range(0, 1));
            vb   = p_valid ? p_vb : 3'($urandom_range(0, 7));
            rd   = ($urandom_range(0, 3) != 0);
            #3;
            // At most one wide word is buffered; a new one fits once the queue drains
            e_inrd = (q.size() == 0) || ((q.size() == 1) && rd);
            chk("rnd_outen", 32'(oen), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_outdata", 32'(odata), 32'(q[0].b));
                chk("rnd_outlast", 32'(olast), 32'(q[0].last));
            end
            chk("rnd_inrd", 32'(inrd), 32'(e_inrd));
            chk("rnd_done", 32'(done), 32'(done_pend));
            done_pend = 0;
            if (rd && (q.size() != 0)) begin
                done_pend = q[0].last;
                void'(q.pop_front());
            end
            if (p_valid && e_inrd) begin
                nb = (!p_last || p_vb == 0 || p_vb > 4) ? 4 : int'(p_vb);
                for (int k = 0; k < nb; k++) begin
                    byte_t e;
                    e.b    = p_data[8*k +: 8];
                    e.last = p_last && (k == nb - 1);
                    q.push_back(e);
                end
                p_valid = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
